// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the interrupt controller (INT_CTRL_VECTORED_EN selects vectored mode in int_ctrl)
package int_ctrl_pkg;

    // Per-channel request FSM; encodings are visible in the status register.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } chan_state_t;

    // Config register map.
    localparam logic [1:0] CFG_ENABLE  = 2'd0;
    localparam logic [1:0] CFG_FIQSEL  = 2'd1;
    localparam logic [1:0] CFG_PENDING = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

    // Default vector bases.
    localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h0000_0020;
    localparam logic [31:0] FIQ_VEC_DEFAULT = 32'h0000_0040;

    // Mask with the low n bits set; keeps register bits above the source count at zero.
    function automatic logic [31:0] src_mask(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-wins priority encoder with valid flag
module int_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [4:0]       id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 5'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - IRQ/FIQ interrupt controller top (INT_CTRL_VECTORED_EN adds id-scaled vector offsets)
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC   = 8,
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEFAULT,
    parameter logic [31:0] FIQ_VEC = FIQ_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic [N_SRC-1:0] src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic             ack_irq,
    input  logic             ack_fiq,
    input  logic             eoi_irq,
    input  logic             eoi_fiq,
    output logic             EX_irq,
    output logic             EX_fiq,
    output logic [31:0]      INT_Vector,
    output logic [4:0]       INT_id
);

    localparam logic [31:0] MASK = src_mask(N_SRC);

    // Config and pending registers are kept 32 bits wide with unused bits held at zero.
    logic [31:0]      enable_r;
    logic [31:0]      fiqsel_r;
    logic [31:0]      pending_r;
    logic [31:0]      pending_nx;
    logic [31:0]      rise;
    logic [31:0]      ack_clr;
    logic [31:0]      w1c;
    logic [N_SRC-1:0] src_q;

    logic [N_SRC-1:0] elig_irq;
    logic [N_SRC-1:0] elig_fiq;
    logic             irq_valid;
    logic             fiq_valid;
    logic [4:0]       irq_win;
    logic [4:0]       fiq_win;

    chan_state_t      irq_state;
    chan_state_t      irq_next;
    chan_state_t      fiq_state;
    chan_state_t      fiq_next;
    logic [4:0]       irq_id;
    logic [4:0]       irq_id_next;
    logic [4:0]       fiq_id;
    logic [4:0]       fiq_id_next;
    logic [31:0]      vec_next;
    logic [4:0]       vid_next;

    assign elig_irq = pending_r[N_SRC-1:0] & enable_r[N_SRC-1:0] & ~fiqsel_r[N_SRC-1:0];
    assign elig_fiq = pending_r[N_SRC-1:0] & enable_r[N_SRC-1:0] &  fiqsel_r[N_SRC-1:0];

    int_prio_enc #(.N_SRC(N_SRC)) u_enc_irq (
        .req   (elig_irq),
        .valid (irq_valid),
        .id    (irq_win)
    );

    int_prio_enc #(.N_SRC(N_SRC)) u_enc_fiq (
        .req   (elig_fiq),
        .valid (fiq_valid),
        .id    (fiq_win)
    );

    // Pending update: edges set, acks and W1C clear, a same-cycle edge wins over a clear.
    always_comb begin
        rise             = '0;
        rise[N_SRC-1:0]  = src & ~src_q;
        ack_clr          = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if ((irq_state == ST_REQ) && ack_irq && (irq_id == 5'(i))) begin
                ack_clr[i] = 1'b1;
            end
            if ((fiq_state == ST_REQ) && ack_fiq && (fiq_id == 5'(i))) begin
                ack_clr[i] = 1'b1;
            end
        end
        w1c        = (cfg_we && (cfg_addr == CFG_PENDING)) ? (cfg_wdata & MASK) : '0;
        pending_nx = ((pending_r & ~ack_clr & ~w1c) | rise) & MASK;
    end

    // Edge-detect history, pending bits and writable config registers.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            src_q     <= '0;
            pending_r <= '0;
            enable_r  <= '0;
            fiqsel_r  <= '0;
        end else begin
            src_q     <= src;
            pending_r <= pending_nx;
            if (cfg_we && (cfg_addr == CFG_ENABLE)) begin
                enable_r <= cfg_wdata & MASK;
            end
            if (cfg_we && (cfg_addr == CFG_FIQSEL)) begin
                fiqsel_r <= cfg_wdata & MASK;
            end
        end
    end

    // Channel FSM next state; IRQ is held in IDLE while FIQ is busy, FIQ is never held.
    always_comb begin
        irq_next    = irq_state;
        irq_id_next = irq_id;
        fiq_next    = fiq_state;
        fiq_id_next = fiq_id;

        case (fiq_state)
            ST_IDLE: begin
                if (fiq_valid) begin
                    fiq_next    = ST_REQ;
                    fiq_id_next = fiq_win;
                end
            end
            ST_REQ:     if (ack_fiq) fiq_next = ST_SERVICE;
            ST_SERVICE: if (eoi_fiq) fiq_next = ST_IDLE;
            default:    fiq_next = ST_IDLE;
        endcase

        case (irq_state)
            ST_IDLE: begin
                if (irq_valid && (fiq_state == ST_IDLE)) begin
                    irq_next    = ST_REQ;
                    irq_id_next = irq_win;
                end
            end
            ST_REQ:     if (ack_irq) irq_next = ST_SERVICE;
            ST_SERVICE: if (eoi_irq) irq_next = ST_IDLE;
            default:    irq_next = ST_IDLE;
        endcase
    end

    // Vector source: FIQ while it is requesting, otherwise the (held) IRQ id.
    always_comb begin
        if (fiq_next == ST_REQ) begin
            vid_next = fiq_id_next;
`ifdef INT_CTRL_VECTORED_EN
            vec_next = FIQ_VEC + {25'b0, fiq_id_next, 2'b00};
`else
            vec_next = FIQ_VEC;
`endif
        end else begin
            vid_next = irq_id_next;
`ifdef INT_CTRL_VECTORED_EN
            vec_next = IRQ_VEC + {25'b0, irq_id_next, 2'b00};
`else
            vec_next = IRQ_VEC;
`endif
        end
    end

    // FSM state, latched ids and the registered CPU-facing request/vector outputs.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            irq_state  <= ST_IDLE;
            fiq_state  <= ST_IDLE;
            irq_id     <= '0;
            fiq_id     <= '0;
            EX_irq     <= 1'b0;
            EX_fiq     <= 1'b0;
            INT_Vector <= IRQ_VEC;
            INT_id     <= '0;
        end else begin
            irq_state  <= irq_next;
            fiq_state  <= fiq_next;
            irq_id     <= irq_id_next;
            fiq_id     <= fiq_id_next;
            EX_irq     <= (irq_next == ST_REQ);
            EX_fiq     <= (fiq_next == ST_REQ);
            INT_Vector <= vec_next;
            INT_id     <= vid_next;
        end
    end

    // Combinational register read.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_ENABLE:  cfg_rdata = enable_r;
            CFG_FIQSEL:  cfg_rdata = fiqsel_r;
            CFG_PENDING: cfg_rdata = pending_r;
            CFG_STATUS:  cfg_rdata = {17'b0, fiq_state, fiq_id, 1'b0, irq_state, irq_id};
            default:     cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - table-driven self-checking bench for int_ctrl
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [7:0]  src = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        ack_irq = 1'b0;
    logic        ack_fiq = 1'b0;
    logic        eoi_irq = 1'b0;
    logic        eoi_fiq = 1'b0;
    logic        EX_irq;
    logic        EX_fiq;
    logic [31:0] INT_Vector;
    logic [4:0]  INT_id;

    int errors = 0;
    int checks = 0;

    int_ctrl #(.N_SRC(8)) dut (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .src        (src),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .ack_irq    (ack_irq),
        .ack_fiq    (ack_fiq),
        .eoi_irq    (eoi_irq),
        .eoi_fiq    (eoi_fiq),
        .EX_irq     (EX_irq),
        .EX_fiq     (EX_fiq),
        .INT_Vector (INT_Vector),
        .INT_id     (INT_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  s;
        logic        we;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [3:0]  ae;
        logic        ei;
        logic        ef;
        logic [4:0]  id;
        logic [31:0] vec;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] vi(input logic [4:0] id);
`ifdef INT_CTRL_VECTORED_EN
        return 32'h20 + {25'b0, id, 2'b00};
`else
        return 32'h20;
`endif
    endfunction

    function automatic logic [31:0] vf(input logic [4:0] id);
`ifdef INT_CTRL_VECTORED_EN
        return 32'h40 + {25'b0, id, 2'b00};
`else
        return 32'h40;
`endif
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // ae = {ack_irq, ack_fiq, eoi_irq, eoi_fiq}
    task automatic add(input logic [7:0] s, input logic we, input logic [1:0] a, input logic [31:0] wd,
                       input logic [3:0] ae, input logic ei, input logic ef, input logic [4:0] id,
                       input logic [31:0] vec, input logic [31:0] rd);
        vec_t v;
        v = '{s, we, a, wd, ae, ei, ef, id, vec, rd};
        tbl.push_back(v);
    endtask

    initial begin
        // IRQ source 0 basic flow
        add(8'h00, 1, 0, 32'h01, 4'b0000, 0, 0, 0, vi(0), 32'h01);
        add(8'h01, 0, 2, 32'h00, 4'b0000, 0, 0, 0, vi(0), 32'h01);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 1, 0, 0, vi(0), 32'h20);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 1, 0, 0, vi(0), 32'h20);
        add(8'h00, 0, 2, 32'h00, 4'b1000, 0, 0, 0, vi(0), 32'h00);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 0, 0, 0, vi(0), 32'h40);
        add(8'h00, 0, 3, 32'h00, 4'b0010, 0, 0, 0, vi(0), 32'h00);
        // simultaneous sources 1 and 3: lowest index first
        add(8'h00, 1, 0, 32'h0F, 4'b0000, 0, 0, 0, vi(0), 32'h0F);
        add(8'h0A, 0, 2, 32'h00, 4'b0000, 0, 0, 0, vi(0), 32'h0A);
        add(8'h0A, 0, 3, 32'h00, 4'b0000, 1, 0, 1, vi(1), 32'h21);
        add(8'h0A, 0, 2, 32'h00, 4'b1000, 0, 0, 1, vi(1), 32'h08);
        add(8'h0A, 0, 3, 32'h00, 4'b0000, 0, 0, 1, vi(1), 32'h41);
        add(8'h0A, 0, 3, 32'h00, 4'b0010, 0, 0, 1, vi(1), 32'h01);
        add(8'h0A, 0, 3, 32'h00, 4'b0000, 1, 0, 3, vi(3), 32'h23);
        add(8'h0A, 0, 2, 32'h00, 4'b1000, 0, 0, 3, vi(3), 32'h00);
        add(8'h0A, 0, 3, 32'h00, 4'b0010, 0, 0, 3, vi(3), 32'h03);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 0, 0, 3, vi(3), 32'h03);
        // FIQ source 2 preempts IRQ source 1 in service
        add(8'h00, 1, 1, 32'h04, 4'b0000, 0, 0, 3, vi(3), 32'h04);
        add(8'h02, 0, 2, 32'h00, 4'b0000, 0, 0, 3, vi(3), 32'h02);
        add(8'h02, 0, 3, 32'h00, 4'b0000, 1, 0, 1, vi(1), 32'h21);
        add(8'h02, 0, 3, 32'h00, 4'b1000, 0, 0, 1, vi(1), 32'h41);
        add(8'h06, 0, 2, 32'h00, 4'b0000, 0, 0, 1, vi(1), 32'h04);
        add(8'h06, 0, 3, 32'h00, 4'b0000, 0, 1, 2, vf(2), 32'h2241);
        add(8'h06, 0, 3, 32'h00, 4'b0100, 0, 0, 1, vi(1), 32'h4241);
        add(8'h06, 0, 3, 32'h00, 4'b0001, 0, 0, 1, vi(1), 32'h0241);
        add(8'h06, 0, 3, 32'h00, 4'b0010, 0, 0, 1, vi(1), 32'h0201);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 0, 0, 1, vi(1), 32'h0201);
        // masked source 5 stays pending until enabled
        add(8'h20, 0, 2, 32'h00, 4'b0000, 0, 0, 1, vi(1), 32'h20);
        add(8'h20, 0, 3, 32'h00, 4'b0000, 0, 0, 1, vi(1), 32'h0201);
        add(8'h20, 1, 0, 32'h20, 4'b0000, 0, 0, 1, vi(1), 32'h20);
        add(8'h20, 0, 3, 32'h00, 4'b0000, 1, 0, 5, vi(5), 32'h0225);
        add(8'h20, 0, 2, 32'h00, 4'b1000, 0, 0, 5, vi(5), 32'h00);
        add(8'h20, 0, 3, 32'h00, 4'b0010, 0, 0, 5, vi(5), 32'h0205);
        add(8'h00, 0, 3, 32'h00, 4'b0000, 0, 0, 5, vi(5), 32'h0205);
        // W1C racing a new edge: set wins; W1C alone clears
        add(8'h01, 0, 2, 32'h00, 4'b0000, 0, 0, 5, vi(5), 32'h01);
        add(8'h00, 0, 2, 32'h00, 4'b0000, 0, 0, 5, vi(5), 32'h01);
        add(8'h01, 1, 2, 32'h01, 4'b0000, 0, 0, 5, vi(5), 32'h01);
        add(8'h01, 1, 2, 32'h01, 4'b0000, 0, 0, 5, vi(5), 32'h00);
        // ack/eoi outside their states are ignored
        add(8'h00, 0, 3, 32'h00, 4'b1100, 0, 0, 5, vi(5), 32'h0205);
        add(8'h00, 0, 3, 32'h00, 4'b0011, 0, 0, 5, vi(5), 32'h0205);

        // reset state
        repeat (2) @(negedge clk);
        Rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ex_irq", 0, {31'b0, EX_irq}, 32'h0);
        chk("rst_ex_fiq", 0, {31'b0, EX_fiq}, 32'h0);
        chk("rst_vec", 0, INT_Vector, 32'h20);
        chk("rst_id", 0, {27'b0, INT_id}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk("rst_rd", a, cfg_rdata, 32'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            src       = tbl[i].s;
            cfg_we    = tbl[i].we;
            cfg_addr  = tbl[i].a;
            cfg_wdata = tbl[i].wd;
            {ack_irq, ack_fiq, eoi_irq, eoi_fiq} = tbl[i].ae;
            @(posedge clk);
            #1;
            chk("ex_irq", i, {31'b0, EX_irq}, {31'b0, tbl[i].ei});
            chk("ex_fiq", i, {31'b0, EX_fiq}, {31'b0, tbl[i].ef});
            chk("int_id", i, {27'b0, INT_id}, {27'b0, tbl[i].id});
            chk("int_vec", i, INT_Vector, tbl[i].vec);
            chk("rdata", i, cfg_rdata, tbl[i].rd);
        end

        // asynchronous reset while IRQ is in REQ
        @(negedge clk);
        {ack_irq, ack_fiq, eoi_irq, eoi_fiq} = 4'b0;
        src = 8'h00; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h01;
        @(negedge clk);
        cfg_we = 1'b0; src = 8'h01;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ex_irq", 0, {31'b0, EX_irq}, 32'h1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_ex_irq", 0, {31'b0, EX_irq}, 32'h0);
        chk("arst_vec", 0, INT_Vector, 32'h20);
        chk("arst_id", 0, {27'b0, INT_id}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk("arst_rd", a, cfg_rdata, 32'h0);
        end
        @(negedge clk);
        Rst_n = 1'b1;
        src = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_ex_irq", 0, {31'b0, EX_irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
